// File: rtl/if_pc_unit_pkg.sv
// if_pc_unit_pkg: fetch-stage reset/exception vectors, NOP encoding and next-PC select codes
package if_pc_unit_pkg;
   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
   localparam logic [31:0] NOP        = 32'h0000_0000;
   typedef enum logic [1:0] {SEL_SEQ, SEL_BR, SEL_J, SEL_JR} pc_sel_e;
endpackage

// File: rtl/if_pc_unit_pc_next_sel.sv
// if_pc_unit_pc_next_sel: forms the sequential/branch/jump/jump-register targets and picks one by priority
module if_pc_unit_pc_next_sel
   import if_pc_unit_pkg::*;
(
   input  logic [31:0] pc_if,
   input  logic [31:0] if_id_pc_plus4,
   input  logic        if_id_valid,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jump_reg,
   input  logic [31:0] jump_reg_addr,
   output logic [31:0] next_pc,
   output logic        redirect
);
   pc_sel_e     sel;
   logic [31:0] seq, br, j, jr;
   always_comb begin
      seq      = pc_if + 32'd4;
      br       = if_id_pc_plus4 + branch_offset;
      j        = {if_id_pc_plus4[31:28], jump_index, 2'b00};
      jr       = jump_reg_addr & 32'hFFFF_FFFC;
      // a bubble in ID carries no real instruction, so its redirect inputs are ignored
      sel      = !if_id_valid  ? SEL_SEQ :
                 jump_reg      ? SEL_JR  :
                 jump          ? SEL_J   :
                 branch_taken  ? SEL_BR  : SEL_SEQ;
      next_pc  = sel == SEL_JR ? jr :
                 sel == SEL_J  ? j  :
                 sel == SEL_BR ? br : seq;
      redirect = sel != SEL_SEQ;
   end
endmodule

// File: rtl/if_pc_unit.sv
// if_pc_unit: fetch PC register, next-PC selection and IF/ID pipeline register (no delay slot)
module if_pc_unit
   import if_pc_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jump_reg,
   input  logic [31:0] jump_reg_addr,
   input  logic        exc_req,
   input  logic [31:0] instr_in,
   output logic [31:0] pc_if,
   output logic [31:0] if_id_pc_plus4,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid
);
   logic [31:0] next_pc;
   logic        redirect;
   if_pc_unit_pc_next_sel u_sel (
      .pc_if          (pc_if),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_valid    (if_id_valid),
      .branch_taken   (branch_taken),
      .branch_offset  (branch_offset),
      .jump           (jump),
      .jump_index     (jump_index),
      .jump_reg       (jump_reg),
      .jump_reg_addr  (jump_reg_addr),
      .next_pc        (next_pc),
      .redirect       (redirect)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_if          <= RESET_PC;
         if_id_pc_plus4 <= 32'h0;
         if_id_instr    <= NOP;
         if_id_valid    <= 1'b0;
      end else if (exc_req) begin
         pc_if       <= EXC_VECTOR;
         if_id_instr <= NOP;
         if_id_valid <= 1'b0;
      end else if (!stall) begin
         pc_if <= next_pc;
         // a redirect squashes the wrong-path fetch; pc_plus4 is left stale under the bubble
         if (redirect) begin
            if_id_instr <= NOP;
            if_id_valid <= 1'b0;
         end else begin
            if_id_pc_plus4 <= next_pc;
            if_id_instr    <= instr_in;
            if_id_valid    <= 1'b1;
         end
      end
   end
endmodule
